ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED LED set, 0xF4 enable) to the
//  keyboard over the shared open-drain ps2_clk/ps2_data lines. Sits beside the PS/2 keyboard receiver.
//  busy tells system logic to discard receiver output while a command is in flight.
//  Lines are driven low only. Pad logic: ps2_x = x_oe ? 1'b0 : 1'bz, with an external pull-up.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles that ps2_clk is held low before request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles from clock release to ack-done (15 ms @ 50 MHz)
// PORTS
//  clk         in   1  system clock
//  clrn        in   1  asynchronous, active-high reset
//  ps2_clk     in   1  PS/2 clock line, raw and unsynchronised
//  ps2_data    in   1  PS/2 data line, raw and unsynchronised
//  ps2_clk_oe  out  1  1 = pull ps2_clk low
//  ps2_data_oe out  1  1 = pull ps2_data low
//  tx_data     in   8  command byte; sampled when a transfer is accepted
//  tx_valid    in   1  request to send tx_data
//  tx_ready    out  1  1 while in IDLE; transfer accepted when tx_valid & tx_ready
//  busy        out  1  ~tx_ready
//  done        out  1  one-cycle pulse when a transfer ends (success or failure)
//  ack_ok      out  1  device acknowledged the last transfer; held until the next accept
//  err         out  1  last transfer failed (timeout or no ack); held until the next accept
// BEHAVIOUR
//  - Reset (asynchronous, any state):
//    - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0; done=0, ack_ok=0, err=0; tx_ready=1.
//    - Both lines are released immediately, even mid-frame.
//  - Line sync: ps2_clk and ps2_data each pass through a 3-flop synchroniser.
//    - fall = sync[2] & ~sync[1] (falling edge of ps2_clk).
//    - Every decision below uses the synchronised values. oe changes land the cycle after fall is seen.
//  - Frame: shift reg = {stop=1, parity=~^tx_data, tx_data}, sent LSB first.
//    - Start bit 0 is sent as the request-to-send.
//    - Bit value b is driven as ps2_data_oe = ~b.
//  - State machine:
//    - IDLE: on accept, latch tx_data; clear ack_ok and err; go to INHIBIT with the cycle counter at 0.
//      - tx_valid while not in IDLE is ignored.
//    - INHIBIT: clk_oe=1. At count INHIBIT_CYCLES-1, set data_oe=1 (start bit).
//      - Next cycle: go to SEND with clk_oe=0, data_oe=1, bit index=0, timeout counter=0.
//    - SEND: on each fall, drive the next bit.
//      - Edges 1..8: data bits 0..7. Edge 9: parity. Edge 10: stop (data_oe=0). Then go to ACK.
//    - ACK: on the next fall (edge 11), sample the data line. 0 -> ack_ok=1; 1 -> err=1. Go to WAIT_IDLE.
//    - WAIT_IDLE: when the synchronised clk and data are both high, go to IDLE and pulse done.
//      - done is high during the first IDLE cycle and tx_ready is also 1 then, so back-to-back accept is legal.
//  - Timeout:
//    - The counter runs in SEND, ACK and WAIT_IDLE.
//    - At TIMEOUT_CYCLES: release both lines, set err=1, ack_ok=0, go to IDLE and pulse done.
//    - Timeout has priority over a fall in the same cycle.
//  - Counters saturate; none wrap. The bit index is 4 bits and never exceeds 10.
//  - A device clock glitch or an extra fall outside SEND/ACK is ignored.
//  - The receiver sees this frame's clocks; system logic drops rx data while busy=1.
// TESTING (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000; device model clocks 40 clk per half-period)
//  - Reset mid-INHIBIT: both oe go to 0 asynchronously, tx_ready=1, done=0, err=0.
//  - Send 0xED:
//    - clk_oe low for 20 cycles; data_oe rises at cycle 19.
//    - Data_oe after edges 1..10 = 0,1,0,0,1,0,0,0,0,0 (parity=1).
//    - Model acks low on edge 11 -> done pulse, ack_ok=1, err=0.
//  - Send 0x07: parity bit 0 -> data_oe=1 after edge 9. Model samples 0x07 with odd parity OK.
//  - No ack (model leaves data high on edge 11): done pulse, err=1, ack_ok=0.
//  - Device never clocks after RTS: at 2000 cycles both oe=0, err=1, done pulses, back to IDLE.
//  - tx_valid held high through a transfer of 0xF4 then 0x00:
//    - Exactly two frames are sent.
//    - Second accept happens in the done cycle.
//    - tx_valid pulses while busy are ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, clocks out one
// command byte on device-generated clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;

    state_t          state;
    logic [2:0]      clk_sync;
    logic [2:0]      data_sync;
    logic [CW-1:0]   cnt;
    logic [9:0]      shift;
    logic [3:0]      bit_idx;
    logic            fall;
    logic            timeout;
    logic            cnt_sat;

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES));
    assign cnt_sat = (cnt == CW'(CNT_MAX));
    assign busy    = ~tx_ready;

    // Idle bus level is high, so synchronisers reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            shift       <= '0;
            bit_idx     <= '0;
        end else begin
            done <= 1'b0;
            if ((state == SEND || state == ACK || state == WAIT_IDLE) && timeout) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                err         <= 1'b1;
                ack_ok      <= 1'b0;
                done        <= 1'b1;
                tx_ready    <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            shift      <= {1'b1, ~^tx_data, tx_data};
                            ack_ok     <= 1'b0;
                            err        <= 1'b0;
                            cnt        <= '0;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (!cnt_sat) cnt <= cnt + CW'(1);
                        // Start bit appears on the last inhibit cycle, then the clock is released.
                        if (cnt >= CW'(INHIBIT_CYCLES - 1)) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            cnt         <= '0;
                            bit_idx     <= '0;
                            state       <= SEND;
                        end else if (cnt == CW'(INHIBIT_CYCLES - 2)) begin
                            ps2_data_oe <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (!cnt_sat) cnt <= cnt + CW'(1);
                        if (fall) begin
                            ps2_data_oe <= ~shift[bit_idx];
                            bit_idx     <= bit_idx + 4'd1;
                            if (bit_idx == 4'd9) state <= ACK;
                        end
                    end
                    ACK: begin
                        if (!cnt_sat) cnt <= cnt + CW'(1);
                        if (fall) begin
                            if (data_sync[1]) err <= 1'b1;
                            else              ack_ok <= 1'b1;
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (!cnt_sat) cnt <= cnt + CW'(1);
                        if (clk_sync[2] && data_sync[2]) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
